tcdm_bank_ctrl: RTL
===================

# tcdm_bank_ctrl

Front-end controller for one 32-bit single-port TCDM SRAM bank (1024x32 or 2048x32 cut wrapper). It shares the bank between two requesters with round-robin arbitration and converts byte enables into the bank's active-low bit mask. It also sequences bank power: INITN pulse after reset, an optional zero-clear sweep, standby entry after idle time, and a timed wake-up. It sits between the interconnect ports and the bank wrapper, one instance per bank.

## Interface
- ADDR_W, 10, bank word-address width (10 = 1024 words, 11 = 2048 words)
- IDLE_CYCLES, 16, consecutive idle cycles before standby entry (>=1)
- WAKE_CYCLES, 2, cycles between STDBY deassertion and first grant (>=1)
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- REQ  in  2  request per port, held until granted
- GNT  out  2  one-hot grant; the request is accepted in the cycle GNT[i]=1
- WE  in  2  per port, 1 = write, 0 = read
- ADDR  in  2*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
- WDATA  in  64  port i at [i*32 +: 32]
- BE  in  8  byte enables, port i at [i*4 +: 4]
- RVALID  out  2  read data valid for port i
- RDATA  out  32  read data, shared, qualified by RVALID
- BUSY  out  1  high while in INIT, CLEAR or WAKE
- CSN  out  1  bank chip select, active-low
- WEN  out  1  bank write enable, active-low
- WMN  out  32  bank bit mask, active-low (0 = bit written)
- A  out  ADDR_W  bank address
- D  out  32  bank write data
- Q  in  32  bank read data
- INITN  out  1  bank init, active-low
- STDBY  out  1  bank standby

## Operation
- States: INIT, CLEAR, ACTIVE, SLEEP, WAKE. Reset enters INIT.
- INIT: lasts 1 cycle. INITN=0 and BUSY=1; no grants. The next state is CLEAR if the macro is defined, otherwise ACTIVE.
- CLEAR: sweeps addresses 0..2^ADDR_W-1, one per cycle. Each cycle drives CSN=0, WEN=0, WMN=0, D=0. BUSY=1 and no grants. After the last address, go to ACTIVE.
- ACTIVE, arbitration:
  - GNT is combinational from REQ and a priority pointer `ptr`.
  - If only one port requests, that port is granted.
  - If both request, port `ptr` is granted.
  - After any grant to port g, `ptr` <= ~g.
  - Reset value of `ptr` is 0.
- ACTIVE, bank drive on a grant to port g: CSN=0, A=ADDR_g, D=WDATA_g, WEN=~WE[g], WMN[8k+7:8k]={8{~BE_g[k]}}.
- ACTIVE, no grant: CSN=1, WEN=1, WMN=all ones.
- ACTIVE, idle counter: `idle_cnt` increments in each cycle with REQ==0 and clears in any cycle with REQ!=0. At the edge ending the IDLE_CYCLES-th consecutive idle cycle, go to SLEEP.
- SLEEP: STDBY=1, CSN=1, no grants. The first cycle with REQ!=0 moves to WAKE at the next edge; STDBY falls at that edge.
- WAKE: STDBY=0, BUSY=1, no grants for WAKE_CYCLES cycles, then ACTIVE. Requests stay pending.
- Reads: RVALID[g]=1 exactly one cycle after a read grant to g; RDATA=Q in that cycle. Writes produce no RVALID.
- Reset mid-operation (any state, including mid-CLEAR): all state returns to reset values and the sequence restarts at INIT. A pending RVALID is dropped.

## Timing
- Reset values: GNT=0, RVALID=0, BUSY=1, CSN=1, WEN=1, WMN=all ones, A=0, D=0, INITN=0, STDBY=0, RDATA=Q (pass-through).
- Read latency: grant in cycle N, RVALID/RDATA in cycle N+1. Back-to-back grants every cycle are allowed.
- Throughput: 1 access per cycle. Under constant dual requests, ports alternate strictly.
- From reset release to first grant: 1 cycle without the macro, 1+2^ADDR_W cycles with it.
- Wake: from the first REQ in SLEEP to grant takes 1+WAKE_CYCLES cycles.
- All bank outputs are registered except CSN/WEN/WMN/A/D in ACTIVE, which are combinational from REQ/ptr.

## Configuration
- TCDM_BANK_CTRL_CLEAR_EN
  - Defined: the CLEAR state exists, and the bank reads all-zero after every reset.
  - Undefined: no CLEAR state, INIT goes straight to ACTIVE, and bank contents are undefined after reset.

## Test plan
- Reset release, macro undefined: INITN=0 for 1 cycle and BUSY=1. In the cycle after INIT, REQ=2'b01 read of ADDR 0x005 gives GNT=2'b01, then RVALID=2'b01 the next cycle.
- Macro defined, ADDR_W=10: 1024 write cycles to A=0..0x3FF with D=0, WMN=0, BUSY=1. Any later read returns RDATA=0x00000000.
- Both ports request reads continuously at 0x010/0x020 from reset (ptr=0): grants are 01,10,01,10. Each RVALID follows 1 cycle later with the matching Q.
- Port 1 writes WDATA=0xAABBCCDD with BE=4'b0101 to 0x3FF: WEN=0 and WMN=0xFF00FF00. A later read of 0x3FF over a zero-cleared bank returns 0x00BB00DD.
- IDLE_CYCLES=16, WAKE_CYCLES=2: 16 idle cycles set STDBY=1. REQ=2'b10 in SLEEP drops STDBY next edge, BUSY=1 for 2 cycles, then GNT=2'b10 (3 cycles after the REQ).
- RST asserted at clear address 0x100: outputs return to reset values immediately. After release, INIT and a full clear restart from address 0.

Source files
------------

// File: rtl/tcdm_bank_ctrl_if.sv
// rtl/tcdm_bank_ctrl_if.sv - two-port requester bus into one TCDM bank controller
interface tcdm_bank_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic [1:0]          we;
    logic [2*ADDR_W-1:0] addr;
    logic [63:0]         wdata;
    logic [7:0]          be;
    logic [1:0]          rvalid;
    logic [31:0]         rdata;

    modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/tcdm_bank_ctrl.sv
// rtl/tcdm_bank_ctrl.sv - round-robin front end and power sequencer for one TCDM SRAM bank
// Optional zero-clear sweep after reset: define TCDM_BANK_CTRL_CLEAR_EN.
module tcdm_bank_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    tcdm_bank_ctrl_if.slave   bus,
    output logic              busy,
    output logic              csn,
    output logic              wen,
    output logic [31:0]       wmn,
    output logic [ADDR_W-1:0] a,
    output logic [31:0]       d,
    input  logic [31:0]       q,
    output logic              initn,
    output logic              stdby
);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int WW = $clog2(WAKE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_CLEAR,
        S_ACTIVE,
        S_SLEEP,
        S_WAKE
    } state_t;

    state_t            state;
    logic              ptr;
    logic [IW-1:0]     idle_cnt;
    logic [WW-1:0]     wake_cnt;
    logic [1:0]        rvalid_q;
    logic              busy_q;
    logic              initn_q;
    logic              stdby_q;
    logic              clr_q;
    logic [ADDR_W-1:0] a_q;

    logic [1:0]        gnt_c;
    logic              g;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_be;

    always_comb begin
        gnt_c = 2'b00;
        if (state == S_ACTIVE) begin
            if (bus.req == 2'b11)
                gnt_c = ptr ? 2'b10 : 2'b01;
            else
                gnt_c = bus.req;
        end
    end

    assign g         = gnt_c[1];
    assign sel_addr  = g ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
    assign sel_wdata = g ? bus.wdata[63:32] : bus.wdata[31:0];
    assign sel_be    = g ? bus.be[7:4] : bus.be[3:0];

    // Outside a grant the bank sees the registered idle/clear drive.
    always_comb begin
        csn = ~clr_q;
        wen = ~clr_q;
        wmn = {32{~clr_q}};
        a   = a_q;
        d   = '0;
        if (|gnt_c) begin
            csn = 1'b0;
            wen = ~bus.we[g];
            a   = sel_addr;
            d   = sel_wdata;
            for (int k = 0; k < 4; k++)
                wmn[8*k +: 8] = {8{~sel_be[k]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_INIT;
            ptr      <= 1'b0;
            idle_cnt <= '0;
            wake_cnt <= '0;
            rvalid_q <= 2'b00;
            busy_q   <= 1'b1;
            initn_q  <= 1'b0;
            stdby_q  <= 1'b0;
            clr_q    <= 1'b0;
            a_q      <= '0;
        end else begin
            rvalid_q <= gnt_c & ~bus.we;
            if (|gnt_c)
                ptr <= ~g;
            case (state)
                S_INIT: begin
                    initn_q <= 1'b1;
`ifdef TCDM_BANK_CTRL_CLEAR_EN
                    state   <= S_CLEAR;
                    clr_q   <= 1'b1;
                    a_q     <= '0;
`else
                    state   <= S_ACTIVE;
                    busy_q  <= 1'b0;
`endif
                end
`ifdef TCDM_BANK_CTRL_CLEAR_EN
                S_CLEAR: begin
                    if (a_q == {ADDR_W{1'b1}}) begin
                        state  <= S_ACTIVE;
                        busy_q <= 1'b0;
                        clr_q  <= 1'b0;
                        a_q    <= '0;
                    end else begin
                        a_q <= a_q + 1'b1;
                    end
                end
`endif
                S_ACTIVE: begin
                    if (bus.req != 2'b00) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
                        state    <= S_SLEEP;
                        stdby_q  <= 1'b1;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_SLEEP: begin
                    if (bus.req != 2'b00) begin
                        state    <= S_WAKE;
                        stdby_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        wake_cnt <= '0;
                    end
                end
                S_WAKE: begin
                    // Pending requests are held by the ports and granted on ACTIVE entry.
                    if (wake_cnt == WW'(WAKE_CYCLES - 1)) begin
                        state  <= S_ACTIVE;
                        busy_q <= 1'b0;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.gnt    = gnt_c;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = q;
    assign busy       = busy_q;
    assign initn      = initn_q;
    assign stdby      = stdby_q;
endmodule
